// File: rtl/multicycle_decoder.sv
// multicycle_decoder: Moore control FSM for the multicycle ARM-subset core.
// It steps each instruction through fetch, decode, address/execute and
// writeback so that one ALU and one unified memory can be shared. It drives
// the datapath selects and the raw write strobes. The conditional-execution
// logic downstream gates those strobes.
module multicycle_decoder #(
    parameter int ALU_W    = 4,
    parameter int EXT_OPS  = 0,
    parameter int MEM_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic             mem_ready,
    output logic [1:0]       FlagW,
    output logic             PCS,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic             undef,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_reg;
    state_t     state_next;

    // Memory phases advance when the access completes. Without wait states
    // every cycle counts as complete.
    logic       mem_go;
    assign mem_go = (MEM_WAIT == 0) || mem_ready;

    // ALU decode results from Funct[4:1]. They are used in EXEC and in ALUWB.
    logic [2:0] alu_op;
    logic       alu_known;
    logic       alu_cmp;
    logic       alu_arith;
    logic [2:0] alu_ctl_raw;
    logic       branch;

    // State register. Reset returns to FETCH at once, without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Illegal encodings fall through to FETCH.
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:   state_next = mem_go ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   state_next = mem_go ? MEMWB : MEMRD;
            MEMWR:   state_next = mem_go ? FETCH : MEMWR;
            EXECR:   state_next = ALUWB;
            EXECI:   state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    // Data-processing operation decode. CMP reuses the SUB encoding but
    // suppresses the register writeback.
    always_comb begin
        alu_op    = 3'd0;
        alu_known = 1'b1;
        alu_cmp   = 1'b0;
        case (Funct[4:1])
            4'b0100: alu_op = 3'd0;
            4'b0010: alu_op = 3'd1;
            4'b0000: alu_op = 3'd2;
            4'b1100: alu_op = 3'd3;
            4'b0001: begin
                if (EXT_OPS != 0) alu_op = 3'd4;
                else              alu_known = 1'b0;
            end
            4'b1010: begin
                if (EXT_OPS != 0) begin
                    alu_op  = 3'd1;
                    alu_cmp = 1'b1;
                end else begin
                    alu_known = 1'b0;
                end
            end
            default: alu_known = 1'b0;
        endcase
        alu_arith = alu_known && (alu_op == 3'd0 || alu_op == 3'd1);
    end

    // Moore outputs for each state, the Op-driven immediate/register selects,
    // and the PC-write strobe. Everything is held at zero while reset is low.
    always_comb begin
        FlagW       = 2'b00;
        PCS         = 1'b0;
        NextPC      = 1'b0;
        RegW        = 1'b0;
        MemW        = 1'b0;
        IRWrite     = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 2'b00;
        RegSrc      = 2'b00;
        alu_ctl_raw = 3'd0;
        undef       = 1'b0;
        branch      = 1'b0;

        case (state_reg)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_go;
                NextPC    = mem_go;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                undef     = (Op == 2'b11);
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR, EXECI: begin
                ALUSrcB     = (state_reg == EXECI) ? 2'b01 : 2'b00;
                alu_ctl_raw = alu_op;
                undef       = !alu_known;
                if (alu_cmp) begin
                    FlagW = 2'b11;
                end else if (alu_known) begin
                    FlagW = {Funct[0], Funct[0] & alu_arith};
                end
            end
            ALUWB: begin
                RegW = alu_known && !alu_cmp;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase

        case (Op)
            2'b00: begin
                ImmSrc = 2'b00;
                RegSrc = 2'b00;
            end
            2'b01: begin
                ImmSrc = 2'b01;
                RegSrc = Funct[0] ? 2'b00 : 2'b10;
            end
            2'b10: begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: ;
        endcase

        PCS = ((Rd == 4'hF) && RegW) || branch;

        if (!reset) begin
            FlagW       = 2'b00;
            PCS         = 1'b0;
            NextPC      = 1'b0;
            RegW        = 1'b0;
            MemW        = 1'b0;
            IRWrite     = 1'b0;
            AdrSrc      = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ResultSrc   = 2'b00;
            ImmSrc      = 2'b00;
            RegSrc      = 2'b00;
            alu_ctl_raw = 3'd0;
            undef       = 1'b0;
        end
    end

    // Zero-extend the 3-bit operation code to the configured ALU width.
    genvar gi;
    generate
        for (gi = 0; gi < ALU_W; gi++) begin : g_aluctl
            if (gi < 3) begin : g_bit
                assign ALUControl[gi] = alu_ctl_raw[gi];
            end else begin : g_zero
                assign ALUControl[gi] = 1'b0;
            end
        end
    endgenerate

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Testbench for multicycle_decoder, built with extended ops and memory wait
// states enabled. Each instruction is expanded into its expected
// cycle-by-cycle phase list, and each cycle is checked against a reference
// model.
module tb_multicycle_decoder;

    localparam int EXT = 1;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_MEMADR = 2;
    localparam int P_MEMRD  = 3;
    localparam int P_MEMWB  = 4;
    localparam int P_MEMWR  = 5;
    localparam int P_EXECR  = 6;
    localparam int P_EXECI  = 7;
    localparam int P_ALUWB  = 8;
    localparam int P_BRANCH = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       mem_ready;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0] ALUControl;
    logic       undef;
    logic [3:0] state;

    logic [21:0] observed;
    assign observed = {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA,
                       ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, undef};

    int checks = 0;
    int errors = 0;

    multicycle_decoder #(.ALU_W(4), .EXT_OPS(1), .MEM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .mem_ready(mem_ready), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .undef(undef), .state(state)
    );

    always #5 clk = ~clk;

    // ALU code from the operation table; -1 means unimplemented.
    function automatic int alu_code(input logic [3:0] f);
        case (f)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b0001: return (EXT != 0) ? 4 : -1;
            4'b1010: return (EXT != 0) ? 1 : -1;
            default: return -1;
        endcase
    endfunction

    // Expected output vector for one cycle of a phase.
    function automatic logic [21:0] expect_out(input int phase, input bit ready,
            input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
            input bit in_reset);
        logic [1:0] fw, srcb, res, imm, rsrc;
        logic pcs, npc, regw, memw, irw, adr, srca, und;
        logic [3:0] aluc;
        int code;
        bit cmp;
        fw = 0; srcb = 0; res = 0; imm = 0; rsrc = 0;
        pcs = 0; npc = 0; regw = 0; memw = 0; irw = 0; adr = 0; srca = 0; und = 0;
        aluc = 0;
        if (in_reset) return '0;
        code = alu_code(funct[4:1]);
        cmp  = (EXT != 0) && (funct[4:1] == 4'b1010);
        if (op == 2'b01) begin
            imm = 2'b01;
            rsrc = funct[0] ? 2'b00 : 2'b10;
        end else if (op == 2'b10) begin
            imm = 2'b10;
            rsrc = 2'b01;
        end
        case (phase)
            P_FETCH: begin srca = 1; srcb = 2; res = 2; irw = ready; npc = ready; end
            P_DECODE: begin srca = 1; srcb = 2; res = 2; und = (op == 2'b11); end
            P_MEMADR: srcb = 1;
            P_MEMRD: adr = 1;
            P_MEMWB: begin res = 1; regw = 1; end
            P_MEMWR: begin adr = 1; memw = 1; end
            P_EXECR, P_EXECI: begin
                srcb = (phase == P_EXECI) ? 2'b01 : 2'b00;
                if (code < 0) begin
                    und = 1;
                end else begin
                    aluc = 4'(code);
                    if (cmp) fw = 2'b11;
                    else fw = {funct[0], funct[0] & (code == 0 || code == 1)};
                end
            end
            P_ALUWB: regw = (code >= 0) && !cmp;
            P_BRANCH: begin srcb = 1; res = 2; pcs = 1; end
            default: ;
        endcase
        if (regw && rd == 4'hF) pcs = 1;
        return {fw, pcs, npc, regw, memw, irw, adr, srca, srcb, res, imm, rsrc, aluc, und};
    endfunction

    // Runs one instruction starting in FETCH, just after a rising edge.
    // A wait of -1 picks a random count (0..2). abort_at >= 0 asserts reset
    // in that cycle of the instruction.
    task automatic run_instr(input string name, input logic [1:0] op,
            input logic [5:0] funct, input logic [3:0] rd,
            input int fetch_wait, input int mem_wait, input int abort_at);
        int ph[$];
        bit rdy[$];
        int n;
        int exp_s;
        logic [21:0] exp_o;
        bit ab;
        n = (fetch_wait < 0) ? $urandom_range(0, 2) : fetch_wait;
        repeat (n) begin ph.push_back(P_FETCH); rdy.push_back(1'b0); end
        ph.push_back(P_FETCH); rdy.push_back(1'b1);
        ph.push_back(P_DECODE); rdy.push_back(1'($urandom_range(0, 1)));
        n = (mem_wait < 0) ? $urandom_range(0, 2) : mem_wait;
        case (op)
            2'b00: begin
                ph.push_back(funct[5] ? P_EXECI : P_EXECR); rdy.push_back(1'($urandom_range(0, 1)));
                ph.push_back(P_ALUWB); rdy.push_back(1'($urandom_range(0, 1)));
            end
            2'b01: begin
                ph.push_back(P_MEMADR); rdy.push_back(1'($urandom_range(0, 1)));
                repeat (n) begin ph.push_back(funct[0] ? P_MEMRD : P_MEMWR); rdy.push_back(1'b0); end
                ph.push_back(funct[0] ? P_MEMRD : P_MEMWR); rdy.push_back(1'b1);
                if (funct[0]) begin ph.push_back(P_MEMWB); rdy.push_back(1'($urandom_range(0, 1))); end
            end
            2'b10: begin
                ph.push_back(P_BRANCH); rdy.push_back(1'($urandom_range(0, 1)));
            end
            default: ;
        endcase
        if (abort_at >= ph.size()) abort_at = ph.size() - 1;
        Op = op; Funct = funct; Rd = rd;
        for (int i = 0; i < ph.size(); i++) begin
            ab = (i == abort_at);
            mem_ready = rdy[i];
            if (ab) reset = 1'b0;
            #4;
            exp_s = ab ? P_FETCH : ph[i];
            exp_o = expect_out(ph[i], rdy[i], op, funct, rd, ab);
            checks++;
            if (state !== 4'(exp_s)) begin
                errors++;
                $display("FAIL %s state cycle %0d: got %0d expected %0d", name, i, state, exp_s);
            end
            checks++;
            if (observed !== exp_o) begin
                errors++;
                $display("FAIL %s outputs cycle %0d phase %0d: got %h expected %h", name, i, ph[i], observed, exp_o);
            end
            @(posedge clk); #1;
            if (ab) begin
                #4;
                checks++;
                if (state !== 4'd0 || observed !== 22'd0) begin
                    errors++;
                    $display("FAIL %s held_reset: got state %0d outs %h expected 0 0", name, state, observed);
                end
                @(posedge clk); #1;
                reset = 1'b1;
                break;
            end
        end
        $display("instr %s op=%b funct=%b rd=%h cycles=%0d abort=%0d", name, op, funct, rd, ph.size(), abort_at);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'($urandom);
            mem_ready = 1'($urandom);
            #4;
            checks++;
            if (state !== 4'd0 || observed !== 22'd0) begin
                errors++;
                $display("FAIL reset_low cycle %0d: got state %0d outs %h expected 0 0", i, state, observed);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        run_instr("add_reg", 2'b00, 6'b001000, 4'b0011, 0, 0, -1);
    endtask

    task automatic test_ldr_wait();
        run_instr("ldr_wait", 2'b01, 6'b011001, 4'd5, 0, 2, -1);
        run_instr("ldr_pc", 2'b01, 6'b011001, 4'hF, 1, 0, -1);
    endtask

    task automatic test_str();
        run_instr("str", 2'b01, 6'b011000, 4'd2, 0, 0, -1);
        run_instr("str_wait", 2'b01, 6'b011000, 4'd7, 0, 2, -1);
    endtask

    task automatic test_branch();
        run_instr("branch", 2'b10, 6'($urandom), 4'($urandom), 0, 0, -1);
    endtask

    task automatic test_cmp_undef();
        run_instr("cmp_imm", 2'b00, 6'b110101, 4'($urandom), 0, 0, -1);
        run_instr("eor_s", 2'b00, 6'b000011, 4'hF, 0, 0, -1);
        run_instr("dp_unknown", 2'b00, 6'b011111, 4'hF, 0, 0, -1);
        run_instr("op11", 2'b11, 6'($urandom), 4'($urandom), 0, 0, -1);
    endtask

    task automatic test_random();
        logic [3:0] codes [7];
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        codes = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b0111};
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            if (op == 2'b00) f[4:1] = codes[$urandom_range(0, 6)];
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            run_instr("random", op, f, rd, -1, -1, -1);
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 6; k++) begin
            run_instr("abort", 2'($urandom_range(0, 2)), 6'($urandom), 4'hF, -1, -1, $urandom_range(1, 4));
        end
        run_instr("after_abort", 2'b00, 6'b101001, 4'hF, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_add", 2'b00, 6'b001001, 4'd1, 0, 0, -1);
        run_instr("b2b_sub", 2'b00, 6'b100101, 4'd2, 0, 0, -1);
        run_instr("b2b_orr", 2'b00, 6'b011000, 4'hF, 0, 0, -1);
        run_instr("b2b_and", 2'b00, 6'b000001, 4'd4, 0, 0, -1);
        run_instr("b2b_b", 2'b10, 6'd0, 4'd0, 0, 0, -1);
        run_instr("b2b_ldr", 2'b01, 6'b011001, 4'd6, 0, 0, -1);
    endtask

    initial begin
        reset = 1'b0;
        Op = 2'b00; Funct = 6'd0; Rd = 4'd0; mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_ldr_wait();
        test_str();
        test_branch();
        test_cmp_undef();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_decoder.md
# multicycle_decoder

Parametrised multicycle successor to the single-cycle instruction decoder in the ARM-subset processor. A Moore state machine sequences each instruction over 3–5 cycles (plus memory wait states) so one ALU and one unified memory are shared between fetch, address and execute. It sits between the instruction register and the conditional-execution logic. It drives the datapath mux selects and the raw write strobes (PCS, NextPC, RegW, MemW, IRWrite); the conditional-execution logic gates those strobes.

## Interface
- ALU_W, 4: ALUControl width; ≥3.
- EXT_OPS, 0: 1 enables EOR and CMP decode.
- MEM_WAIT, 0: 1 makes FETCH/MEMRD/MEMWR wait on mem_ready; 0 ignores mem_ready.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- Op  in  2  instruction class.
- Funct  in  6  instruction bits [25:20].
- Rd  in  4  destination register.
- mem_ready  in  1  memory access complete this cycle.
- FlagW  out  2  flag write enables {NZ, CV}.
- PCS, NextPC, RegW, MemW, IRWrite  out  1 each  raw write strobes.
- AdrSrc, ALUSrcA  out  1 each  memory-address select and ALU A select.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath selects.
- ALUControl  out  ALU_W  ALU operation.
- undef  out  1  one-cycle pulse on an unimplemented instruction.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10–15 are illegal and go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR; Op=00 with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH with undef=1.
  - MEMADR: Funct[0]=1→MEMRD, else→MEMWR.
  - MEMRD→MEMWB.
  - MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
  - EXECR, EXECI→ALUWB.
- Outputs are Moore. Any select not listed below is 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ALUControl=ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALU decode active.
  - EXECI: ALUSrcB=01, ALU decode active.
  - ALUWB: RegW=1, except RegW=0 for CMP.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALUControl=ADD, Branch=1.
- ImmSrc and RegSrc are combinational from Op:
  - Op=00: ImmSrc=00, RegSrc=00.
  - Op=01: ImmSrc=01; RegSrc=10 for STR, 00 for LDR.
  - Op=10: ImmSrc=10, RegSrc=01.
- ALU decode (EXECR/EXECI) on Funct[4:1]:
  - 0100→ADD 0, 0010→SUB 1, 0000→AND 2, 1100→ORR 3.
  - EXT_OPS=1 adds: 0001→EOR 4; 1010→CMP, driving SUB 1 with writeback suppressed.
  - Unknown code→ALUControl=0, FlagW=00, undef=1 in that EXEC cycle; ALUWB still runs with RegW=0.
- FlagW, asserted only in EXEC states:
  - FlagW[1]=Funct[0].
  - FlagW[0]=Funct[0] & (op is ADD or SUB or CMP).
  - CMP forces FlagW=11.
- PCS = (Rd==1111 & RegW) | Branch.
- ALUControl is zero-extended to ALU_W.

## Timing
- Reset low: state=FETCH immediately. While reset is low, every strobe and every output is forced 0: PCS, NextPC, RegW, MemW, IRWrite, undef, FlagW, ALUControl and all selects.
- Reset release: the first rising edge with reset high is the FETCH cycle. Strobes become active combinationally after release.
- Reset asserted mid-instruction aborts it in the same cycle with no further strobes.
- Cycle counts with MEM_WAIT=0: data-processing 4, LDR 5, STR 4, B 3.
- MEM_WAIT=1:
  - FETCH, MEMRD and MEMWR advance only on a rising edge where mem_ready=1.
  - While waiting, the state holds; MemW stays high in MEMWR. IRWrite and NextPC are asserted only in the cycle where mem_ready=1.
  - A mem_ready pulse outside those three states is ignored.
- Decode outputs follow Funct/Op with zero latency. Op, Funct and Rd must stay stable from DECODE to instruction end (the IR holds them).

## Test plan
- Reset held low 3 cycles, then released → all outputs 0 while low; state=0 after release; IRWrite=1, NextPC=1 in the first cycle.
- ADD register (Op=00, Funct=001000, Rd=0011) → state sequence 0,1,6,8,0; ALUControl=0000 in EXECR; RegW=1 only in ALUWB; PCS=0; FlagW=00.
- LDR (Op=01, Funct=011001), MEM_WAIT=1, mem_ready low 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0; ResultSrc=01 with RegW=1 in MEMWB.
- STR (Op=01, Funct=011000) → sequence 0,1,2,5,0; MemW=1 only in MEMWR; RegSrc=10.
- B (Op=10) → sequence 0,1,9,0; PCS=1 in BRANCH; ImmSrc=10.
- EXT_OPS=1, CMP immediate (Op=00, Funct=110101) → ALUControl=0001 and FlagW=11 in EXECI, RegW=0 in ALUWB. Op=11 → undef=1 in DECODE, next state 0.
